// File: rtl/bcd_xs3_pkg.sv
// Shared definitions for the BCD-to-excess-3 sequencing controller.
//   DIGIT_W    : width of one BCD / excess-3 digit
//   XS3_OFFSET : excess-3 bias added to each digit
//   BCD_MAX    : largest legal BCD digit
//   state_t    : controller state encoding
package bcd_xs3_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  XS3_OFFSET = 4'd3;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/xs3_digit_conv.sv
// Combinational single-digit BCD to excess-3 converter.
//   bcd : input digit (any 4-bit code)
//   xs3 : bcd + 3, wrapping mod 16 for codes 13..15
module xs3_digit_conv
  import bcd_xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [DIGIT_W-1:0] xs3
);

  assign xs3 = bcd + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequencing controller: accepts a packed NDIGITS-digit BCD word, converts it
// one digit per cycle (LSD first) through a single shared xs3_digit_conv, and
// returns the packed excess-3 word over a valid/ready handshake.
// Optional macro BCD_XS3_ERRCHK_EN adds out_err_mask (per-digit code > 9 flag).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_bcd packed BCD (digit 0 = [3:0])
//   out_valid/out_ready   : output handshake, out_xs3 packed excess-3 result
//   busy                  : high while converting or holding a result
//   out_err_mask          : per-digit invalid-BCD flags (BCD_XS3_ERRCHK_EN only)
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_bcd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_xs3,
  output logic                   busy
`ifdef BCD_XS3_ERRCHK_EN
  ,
  output logic [NDIGITS-1:0]     out_err_mask
`endif
);

  // Index width is kept at least 1 so NDIGITS=1 still has a legal counter.
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [4*NDIGITS-1:0]   word_q;
  logic [4*NDIGITS-1:0]   result_q;
  logic [DIGIT_W-1:0]     digit_in;
  logic [DIGIT_W-1:0]     digit_xs3;
  logic                   accept;
  logic                   last_digit;

  assign accept     = in_valid && in_ready;
  assign last_digit = (idx_q == IDX_W'(NDIGITS - 1));

  // Select the digit currently being converted.
  always_comb begin
    digit_in = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_in = word_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  xs3_digit_conv u_conv (
    .bcd (digit_in),
    .xs3 (digit_xs3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      idx_q    <= '0;
      word_q   <= in_bcd;
      result_q <= '0;
    end else if (state_q == CONV) begin
      for (int unsigned i = 0; i < NDIGITS; i++) begin
        if (idx_q == IDX_W'(i)) result_q[i*DIGIT_W +: DIGIT_W] <= digit_xs3;
      end
      if (!last_digit) idx_q <= idx_q + 1'b1;
    end
  end

  assign out_xs3 = result_q;

`ifdef BCD_XS3_ERRCHK_EN
  logic [NDIGITS-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (accept) begin
      err_q <= '0;
    end else if (state_q == CONV) begin
      for (int unsigned i = 0; i < NDIGITS; i++) begin
        if (idx_q == IDX_W'(i)) err_q[i] <= (digit_in > BCD_MAX);
      end
    end
  end

  assign out_err_mask = err_q;
`endif

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Directed self-checking bench for bcd_xs3_seq_ctrl (NDIGITS=4 and NDIGITS=1).
module tb_bcd_xs3_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_bcd, out_xs3;
`ifdef BCD_XS3_ERRCHK_EN
  logic [3:0]  out_err_mask;
`endif

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [3:0]  s_in_bcd, s_out_xs3;
`ifdef BCD_XS3_ERRCHK_EN
  logic [0:0]  s_err_mask;
`endif

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int          lat;

  bcd_xs3_seq_ctrl #(.NDIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_xs3(out_xs3),
    .busy(busy)
`ifdef BCD_XS3_ERRCHK_EN
    , .out_err_mask(out_err_mask)
`endif
  );

  bcd_xs3_seq_ctrl #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bcd(s_in_bcd),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_xs3(s_out_xs3),
    .busy(s_busy)
`ifdef BCD_XS3_ERRCHK_EN
    , .out_err_mask(s_err_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for out_valid on the 4-digit DUT; returns edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_bcd = '0; s_out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_xs3", 32'(out_xs3), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick;

    // 1: basic conversion, latency, return to IDLE
    in_bcd = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    check("t1_in_ready_idle", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    check("t1_busy_conv", 32'(busy), 32'd1);
    check("t1_in_ready_conv", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_xs3", 32'(out_xs3), 32'h4567);
    tick;
    check("t1_idle_in_ready", 32'(in_ready), 32'd1);
    check("t1_idle_out_valid", 32'(out_valid), 32'd0);

    // 2: back-to-back words, in_ready low throughout CONV/DONE
    in_bcd = 16'h9990; in_valid = 1'b1;
    tick;
    in_bcd = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      check("t2_in_ready_low", 32'(in_ready), 32'd0);
      tick;
    end
    check("t2_in_ready_done", 32'(in_ready), 32'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_xs3_a", 32'(out_xs3), 32'hCCC3);
    tick;
    check("t2_idle_between", 32'(busy), 32'd0);
    tick;
    in_valid = 1'b0;
    check("t2_accept2", 32'(busy), 32'd1);
    wait_valid(lat);
    check("t2_latency2", 32'(lat), 32'd4);
    check("t2_xs3_b", 32'(out_xs3), 32'h3333);
    tick;

    // 3: backpressure, new request held off until after the handshake
    out_ready = 1'b0;
    in_bcd = 16'h9876; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid(lat);
    check("t3_latency", 32'(lat), 32'd4);
    in_bcd = 16'h4321; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_xs3", 32'(out_xs3), 32'hCBA9);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    check("t3_release_valid", 32'(out_valid), 32'd0);
    check("t3_no_accept_busy", 32'(busy), 32'd0);
    tick;
    in_valid = 1'b0;
    check("t3_accept_next", 32'(busy), 32'd1);
    wait_valid(lat);
    check("t3_xs3_next", 32'(out_xs3), 32'h7654);
    tick;

    // 4: asynchronous reset mid-conversion
    in_bcd = 16'h1234; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    check("t4_rst_out_valid", 32'(out_valid), 32'd0);
    check("t4_rst_in_ready", 32'(in_ready), 32'd1);
    check("t4_rst_xs3", 32'(out_xs3), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick;
    check("t4_idle_after", 32'(busy), 32'd0);
    in_bcd = 16'h0505; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid(lat);
    check("t4_latency", 32'(lat), 32'd4);
    check("t4_xs3", 32'(out_xs3), 32'h3838);
    tick;

    // 5/6: invalid codes wrap mod 16
    in_bcd = 16'h00A0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid(lat);
    check("t5_xs3_A", 32'(out_xs3), 32'h33D3);
`ifdef BCD_XS3_ERRCHK_EN
    check("t5_mask_A", 32'(out_err_mask), 32'b0010);
`endif
    tick;
    in_bcd = 16'hF000; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_valid(lat);
    check("t5_xs3_F", 32'(out_xs3), 32'h2333);
`ifdef BCD_XS3_ERRCHK_EN
    check("t5_mask_F", 32'(out_err_mask), 32'b1000);
`endif
    tick;

    // NDIGITS=1 instance
    s_out_ready = 1'b1;
    s_in_bcd = 4'h7; s_in_valid = 1'b1;
    check("n1_in_ready", 32'(s_in_ready), 32'd1);
    tick;
    s_in_valid = 1'b0;
    check("n1_conv_no_valid", 32'(s_out_valid), 32'd0);
    tick;
    check("n1_valid", 32'(s_out_valid), 32'd1);
    check("n1_xs3_7", 32'(s_out_xs3), 32'hA);
    tick;
    check("n1_idle", 32'(s_in_ready), 32'd1);
    s_in_bcd = 4'hE; s_in_valid = 1'b1;
    tick;
    s_in_valid = 1'b0;
    tick;
    check("n1_xs3_E", 32'(s_out_xs3), 32'h1);
`ifdef BCD_XS3_ERRCHK_EN
    check("n1_mask_E", 32'(s_err_mask), 32'd1);
`endif
    tick;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
Name: bcd_xs3_seq_ctrl

Overview:
Sequencing controller for the BCD-to-excess-3 digit converter. It accepts a packed multi-digit BCD word over a valid/ready handshake. It then drives one shared single-digit converter one digit per cycle, least-significant digit first, and assembles the packed excess-3 result. The result is returned over a second valid/ready handshake. The block sits between the lab's BCD input register and its display/output stage, so one converter is time-shared across all digits.

Parameters:
NDIGITS, 4, number of BCD digits per word (1..8); data width is 4*NDIGITS.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_bcd is valid.
in_ready  output  1  block can accept a word.
in_bcd  input  4*NDIGITS  packed BCD word; digit 0 is bits [3:0].
out_valid  output  1  out_xs3 holds a completed result.
out_ready  input  1  consumer accepts the result.
out_xs3  output  4*NDIGITS  packed excess-3 result; digit i is bits [4i+3:4i].
busy  output  1  high in CONV or DONE.
out_err_mask  output  NDIGITS  per-digit invalid-BCD flags (only with BCD_XS3_ERRCHK_EN).

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low regardless of clk:
  - state=IDLE, digit index=0, latched word=0.
  - in_ready=1, out_valid=0, busy=0.
  - out_xs3=0, out_err_mask=0.
- Reset mid-operation: any word in flight is discarded silently. After release the block is in IDLE with no residue.
- IDLE state:
  - in_ready=1.
  - On a clk edge with in_valid&in_ready: latch in_bcd, clear result and mask, set idx=0, go to CONV.
- CONV state:
  - in_ready=0.
  - Each cycle, digit idx of the latched word feeds the converter, and the converter output is written into result slot idx on the edge.
  - If idx==NDIGITS-1, go to DONE. Otherwise idx increments.
- DONE state:
  - out_valid=1.
  - out_xs3 and out_err_mask hold stable while out_ready=0; backpressure is unbounded.
  - On an edge with out_ready=1, go to IDLE.
- No accept in the cycle the result is consumed. in_valid asserted during CONV or DONE is ignored until IDLE.
- Latency: out_valid rises exactly NDIGITS edges after the accept edge. Minimum throughput is one word per NDIGITS+2 cycles.
- Arithmetic:
  - Converter output = digit + 3, truncated to 4 bits (mod 16), for all 16 input codes.
  - Valid codes 0..9 map to 3..12.
  - Invalid codes 10..15 map to 13, 14, 15, 0, 1, 2.
- out_xs3 is registered; no combinational path from in_bcd to out_xs3.
- NDIGITS=1: CONV lasts one cycle, then DONE.

Optional Feature:
Macro BCD_XS3_ERRCHK_EN.
- Defined:
  - out_err_mask port exists.
  - Bit i is set in the CONV cycle that processes digit i if that digit > 9; it is registered alongside out_xs3.
  - The conversion value itself is unchanged.
- Undefined:
  - Port and logic are absent.
  - Invalid digits are converted mod 16 with no indication.

Decomposition:
- Shared package bcd_xs3_pkg holds:
  - DIGIT_W=4, XS3_OFFSET=4'd3, BCD_MAX=4'd9.
  - State encoding IDLE=2'b00, CONV=2'b01, DONE=2'b10.
- One natural sub-module: xs3_digit_conv. It is the combinational 4-bit digit+3 converter, instantiated once and time-shared.
- The top-level module contains the FSM, index counter, input/output registers and the optional error mask.

Test Plan:
1. NDIGITS=4, in_bcd=16'h1234, out_ready=1 → out_xs3=16'h4567 exactly 4 edges after accept; IDLE one cycle later.
2. in_bcd=16'h9990 → out_xs3=16'hCCC3. Second word 16'h0000 sent back-to-back → 16'h3333. in_ready is low throughout CONV/DONE.
3. Backpressure: out_ready=0 for 10 cycles after out_valid → out_xs3 stable and out_valid held; a new in_valid is not accepted until the cycle after the out_ready handshake.
4. rst_n pulsed low during CONV (idx=2) → in the same cycle out_valid=0, in_ready=1, out_xs3=0. After release, a new word 16'h0505 → 16'h3838.
5. With BCD_XS3_ERRCHK_EN: in_bcd=16'h00A0 → out_xs3=16'h33D3, out_err_mask=4'b0010. in_bcd=16'hF000 → out_xs3=16'h2333, out_err_mask=4'b1000.
6. Without BCD_XS3_ERRCHK_EN: in_bcd=16'h00A0 → out_xs3=16'h33D3, no error port. NDIGITS=1 build: in_bcd=4'h7 → out_xs3=4'hA after 1 edge.
